// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and load clamp
// Contents: bcd_t (one packed BCD digit), BCD_MAX, BCD_ZERO, bcd_clamp()
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX  = 4'd9;
   localparam bcd_t BCD_ZERO = 4'd0;

   // Forces any non-decimal nibble (A..F) down to 9 so a stored digit is always BCD.
   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single decade stage of the multi-digit BCD counter
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clr             synchronous clear to 0 (highest priority)
//   load            synchronous load of load_digit (clamped to 9)
//   load_digit      digit value to load
//   inc_in          increment this digit on the edge (formed by the parent)
//   q_digit         current digit value, always 0..9
//   at_max          high while q_digit is 9
module bcd_digit
   import bcd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  bcd_t load_digit,
   input  logic inc_in,
   output bcd_t q_digit,
   output logic at_max
);

   assign at_max = (q_digit == BCD_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_digit <= BCD_ZERO;
      end else if (clr) begin
         q_digit <= BCD_ZERO;
      end else if (load) begin
         q_digit <= bcd_clamp(load_digit);
      end else if (inc_in) begin
         q_digit <= at_max ? BCD_ZERO : q_digit + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// rtl/bcd_counter_multi.sv - parametrised multi-digit BCD up-counter with load, clear, saturation and sticky overflow
// Parameters: DIGITS (1..8), SATURATE (0 = wrap at all-9s, 1 = hold at all-9s)
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enb             count enable, one increment per edge
//   clr             synchronous clear of count and ovf
//   load            synchronous parallel load of load_val
//   load_val        packed BCD load value, digit i in [4i+3:4i]
//   q               packed BCD count, digit 0 least significant
//   carry           combinational ripple-out, high in the cycle whose edge wraps
//   ovf             sticky overflow, set by an enabled increment at all-9s
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enb,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   q,
   output logic                  carry,
   output logic                  ovf
);

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] inc_in;
   logic              all_max;
   logic              count_en;

   assign all_max = &at_max;

   // In saturating mode the increment is suppressed at terminal count so every digit holds 9.
   assign count_en = enb & ~(SATURATE & all_max);

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         // Digit i steps only when every lower digit is at 9.
         if (i == 0) begin : g_first
            assign inc_in[i] = count_en;
         end else begin : g_rest
            assign inc_in[i] = inc_in[i-1] & at_max[i-1];
         end

         bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .inc_in     (inc_in[i]),
            .q_digit    (q[4*i +: 4]),
            .at_max     (at_max[i])
         );
      end
   endgenerate

   assign carry = enb & all_max & ~clr & ~load & ~SATURATE;

   // Only an enabled increment at terminal count sets ovf; a load leaves it untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (clr) begin
         ovf <= 1'b0;
      end else if (!load && enb && all_max) begin
         ovf <= 1'b1;
      end
   end

endmodule
